// File: rtl/regfile_wb_queue.sv
// Writeback queue for the 16x16 register file: arbitrates ALU/load results into an
// in-order circular buffer, retires one write per cycle and flags pending-write hazards.
module regfile_wb_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_adr_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_adr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ready_o,
    input  logic              hold_i,
    output logic [ADDR_W-1:0] wadr_o,
    output logic              wen_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [ADDR_W-1:0] haz_adr1_i,
    input  logic [ADDR_W-1:0] haz_adr2_i,
    output logic              haz1_o,
    output logic              haz2_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] adr_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              full_s, empty_s, push_s, pop_s;
    logic [ADDR_W-1:0] push_adr_s;
    logic [DATA_W-1:0] push_data_s;
    logic [PTR_W-1:0]  off_s;

    // Handshake arbitration (MEM over ALU) and drain-side outputs
    always_comb begin
        full_s      = (count_q == CNT_W'(DEPTH));
        empty_s     = (count_q == {CNT_W{1'b0}});
        mem_ready_o = !full_s;
        alu_ready_o = !full_s && !mem_valid_i;
        push_s      = (mem_valid_i || alu_valid_i) && !full_s;
        if (mem_valid_i) begin
            push_adr_s  = mem_adr_i;
            push_data_s = mem_data_i;
        end else begin
            push_adr_s  = alu_adr_i;
            push_data_s = alu_data_i;
        end
        pop_s = !empty_s && !hold_i;
        wen_o = pop_s;
        if (empty_s) begin
            wadr_o  = {ADDR_W{1'b0}};
            wdata_o = {DATA_W{1'b0}};
        end else begin
            wadr_o  = adr_q[rd_ptr_q];
            wdata_o = data_q[rd_ptr_q];
        end
        full_o  = full_s;
        empty_o = empty_s;
        count_o = count_q;
    end

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Hazard match over occupied slots; a slot is live when its distance from the head is below COUNT
    always_comb begin
        haz1_o = 1'b0;
        haz2_o = 1'b0;
        off_s  = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, off_s} < count_q) begin
                if (adr_q[i] == haz_adr1_i) begin
                    haz1_o = 1'b1;
                end else begin
                    haz1_o = haz1_o;
                end
                if (adr_q[i] == haz_adr2_i) begin
                    haz2_o = 1'b1;
                end else begin
                    haz2_o = haz2_o;
                end
            end else begin
                haz1_o = haz1_o;
                haz2_o = haz2_o;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the tail on each accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= {ADDR_W{1'b0}};
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            adr_q[wr_ptr_q]  <= push_adr_s;
            data_q[wr_ptr_q] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic, all compared
// each cycle against a queue-based reference model of the writeback buffer.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int CW    = 3;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid, hold;
    logic [AW-1:0] alu_adr, mem_adr, haz_adr1, haz_adr2;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready, wen, haz1, haz2, full, empty;
    logic [AW-1:0] wadr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] count;

    ent_t          q[$];
    logic [DW-1:0] rf_exp [16];
    bit            rf_written [16];
    logic [DW-1:0] dut_rf [16];
    int            checks = 0;
    int            errors = 0;
    bit            alu_acc, mem_acc, last_alu_ready, last_mem_ready;

    regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid), .alu_adr_i(alu_adr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
        .mem_valid_i(mem_valid), .mem_adr_i(mem_adr), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
        .hold_i(hold), .wadr_o(wadr), .wen_o(wen), .wdata_o(wdata),
        .haz_adr1_i(haz_adr1), .haz_adr2_i(haz_adr2), .haz1_o(haz1), .haz2_o(haz2),
        .count_o(count), .full_o(full), .empty_o(empty)
    );

    always #5 clk = ~clk;

    // Register file as seen through the DUT write port
    always @(posedge clk) begin
        if (wen === 1'b1) dut_rf[wadr] <= wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; checks, clocks the model, returns at next negedge.
    task automatic step();
        bit   full_e, wen_e, haz1_e, haz2_e;
        ent_t e;
        #1;
        full_e = (q.size() == DEPTH);
        wen_e  = (q.size() != 0) && !hold;
        haz1_e = 1'b0;
        haz2_e = 1'b0;
        foreach (q[i]) begin
            if (q[i].adr == haz_adr1) haz1_e = 1'b1;
            if (q[i].adr == haz_adr2) haz2_e = 1'b1;
        end
        last_mem_ready = !full_e;
        last_alu_ready = !full_e && !mem_valid;
        mem_acc = mem_valid && last_mem_ready;
        alu_acc = alu_valid && last_alu_ready;
        check("mem_ready", {31'd0, mem_ready}, {31'd0, last_mem_ready});
        check("alu_ready", {31'd0, alu_ready}, {31'd0, last_alu_ready});
        check("wen",       {31'd0, wen},       {31'd0, wen_e});
        check("wadr",      {28'd0, wadr},  (q.size() != 0) ? {28'd0, q[0].adr}  : 32'd0);
        check("wdata",     {16'd0, wdata}, (q.size() != 0) ? {16'd0, q[0].data} : 32'd0);
        check("haz1",      {31'd0, haz1},      {31'd0, haz1_e});
        check("haz2",      {31'd0, haz2},      {31'd0, haz2_e});
        check("count",     {29'd0, count},     32'(q.size()));
        check("full",      {31'd0, full},      {31'd0, full_e});
        check("empty",     {31'd0, empty},     {31'd0, (q.size() == 0)});
        @(posedge clk);
        if (wen_e) begin
            e = q.pop_front();
            rf_exp[e.adr]     = e.data;
            rf_written[e.adr] = 1'b1;
        end
        if (mem_acc)      q.push_back({mem_adr, mem_data});
        else if (alu_acc) q.push_back({alu_adr, alu_data});
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        hold      = 1'b0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
        step();
    endtask

    initial begin
        int k, n, cyc;
        foreach (rf_exp[i]) begin
            rf_exp[i]     = 16'h0000;
            rf_written[i] = 1'b0;
        end
        rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; hold = 1'b0;
        alu_adr = 4'd0; mem_adr = 4'd0; alu_data = 16'h0; mem_data = 16'h0;
        haz_adr1 = 4'd3; haz_adr2 = 4'd7;
        #2;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_wen",   {31'd0, wen},   32'd0);
        check("rst_wdata", {16'd0, wdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single ALU write
        alu_valid = 1'b1; alu_adr = 4'd3; alu_data = 16'h1234;
        step();
        alu_valid = 1'b0;
        #1;
        check("single_wen",  {31'd0, wen},   32'd1);
        check("single_haz1", {31'd0, haz1},  32'd1);
        check("single_data", {16'd0, wdata}, 32'h1234);
        step();
        step();

        // Arbitration: MEM wins, ALU waits
        alu_valid = 1'b1; alu_adr = 4'd1; alu_data = 16'hAAAA;
        mem_valid = 1'b1; mem_adr = 4'd2; mem_data = 16'hBBBB;
        step();
        check("arb_mem_first", {30'd0, mem_acc, alu_acc}, 32'd2);
        mem_valid = 1'b0;
        step();
        check("arb_alu_second", {31'd0, alu_acc}, 32'd1);
        drain();
        check("arb_rf2", {16'd0, dut_rf[2]}, 32'hBBBB);
        check("arb_rf1", {16'd0, dut_rf[1]}, 32'hAAAA);

        // Fill under HOLD
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_adr = AW'(i); alu_data = DW'(16'h0100 + i);
            step();
        end
        alu_adr = 4'd4; alu_data = 16'h0104;
        step();
        check("fill_full_noready", {31'd0, last_alu_ready}, 32'd0);
        hold = 1'b0;
        k = 0;
        while (!alu_acc && k < 10) begin
            step();
            k++;
        end
        check("fill_adr4_accepted", {31'd0, alu_acc}, 32'd1);
        drain();

        // Same-address hazard
        haz_adr2 = 4'd7;
        hold = 1'b1;
        alu_valid = 1'b1; alu_adr = 4'd7; alu_data = 16'h0001;
        step();
        alu_data = 16'h0002;
        step();
        alu_valid = 1'b0;
        hold = 1'b0;
        #1;
        check("same_haz2", {31'd0, haz2}, 32'd1);
        drain();
        check("same_final", {16'd0, dut_rf[7]}, 32'h0002);

        // Random traffic with random HOLD
        n = 0; cyc = 0; alu_acc = 1'b0; mem_acc = 1'b0;
        while (n < 20 && cyc < 300) begin
            if (!alu_valid || alu_acc) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_adr = AW'($urandom); alu_data = DW'($urandom);
            end
            if (!mem_valid || mem_acc) begin
                mem_valid = ($urandom_range(0, 2) == 0);
                mem_adr = AW'($urandom); mem_data = DW'($urandom);
            end
            hold = ($urandom_range(0, 2) == 0);
            haz_adr1 = AW'($urandom); haz_adr2 = AW'($urandom);
            step();
            if (alu_acc || mem_acc) n++;
            cyc++;
        end
        check("rand_accepts", 32'(n), 32'd20);
        drain();
        for (int i = 0; i < 16; i++) begin
            if (rf_written[i]) check("rf_model", {16'd0, dut_rf[i]}, {16'd0, rf_exp[i]});
        end

        // Asynchronous reset with three entries queued
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_adr = AW'(8 + i); alu_data = DW'(16'hC000 + i);
            step();
        end
        alu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("arst_wen",   {31'd0, wen},   32'd0);
        check("arst_count", {29'd0, count}, 32'd0);
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_wadr",  {28'd0, wadr},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
